// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard port controller.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_RX           = 3'd1,
    ST_TX_INHIBIT   = 3'd2,
    ST_TX_RTS       = 3'd3,
    ST_TX_BITS      = 3'd4,
    ST_TX_ACK       = 3'd5,
    ST_TX_WAIT_IDLE = 3'd6
  } ps2_state_e;

  localparam int unsigned FRAME_BITS = 11;
  localparam logic [3:0]  PARITY_IDX = 4'(FRAME_BITS - 2);
  localparam logic [3:0]  STOP_IDX   = 4'(FRAME_BITS - 1);

  localparam int unsigned STAT_RX_VALID   = 0;
  localparam int unsigned STAT_TX_BUSY    = 1;
  localparam int unsigned STAT_PARITY_ERR = 2;
  localparam int unsigned STAT_FRAME_ERR  = 3;
  localparam int unsigned STAT_ACK_ERR    = 4;
  localparam int unsigned STAT_TIMEOUT    = 5;
  localparam int unsigned STAT_OVERRUN    = 6;

  function automatic logic odd_parity(input logic [7:0] b);
    return ~(^b);
  endfunction

endpackage

// File: rtl/ps2_port_controller_line_sync.sv
// PS/2 pin synchronisers, falling-edge detect on the clock line and the
// delayed sample/drive strobe that follows each falling edge.
module ps2_line_sync
  import ps2_pkg::*;
#(
  parameter int unsigned SAMPLE_DELAY = 8
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic kb_clk_i,
  input  logic kb_data_i,
  output logic clk_s_o,
  output logic data_s_o,
  output logic fall_o,
  output logic strobe_o
);

  localparam int unsigned DLY_W = $clog2(SAMPLE_DELAY + 1);

  logic [1:0]       clk_sync_q;
  logic [1:0]       data_sync_q;
  logic             clk_prev_q;
  logic [DLY_W-1:0] dly_q;
  logic             strobe_q;

  assign clk_s_o  = clk_sync_q[1];
  assign data_s_o = data_sync_q[1];
  assign fall_o   = clk_prev_q & ~clk_sync_q[1];
  assign strobe_o = strobe_q;

  // Idle lines are high, so the synchronisers reset to 1 to avoid a false edge.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      clk_prev_q  <= 1'b1;
      dly_q       <= '0;
      strobe_q    <= 1'b0;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], kb_clk_i};
      data_sync_q <= {data_sync_q[0], kb_data_i};
      clk_prev_q  <= clk_sync_q[1];
      strobe_q    <= 1'b0;
      if (fall_o) begin
        dly_q <= DLY_W'(SAMPLE_DELAY);
      end else if (dly_q != '0) begin
        dly_q    <= dly_q - DLY_W'(1);
        strobe_q <= (dly_q == DLY_W'(1));
      end
    end
  end

endmodule

// File: rtl/ps2_port_controller.sv
// Bidirectional PS/2 keyboard port: CPU data/status registers, device-to-host
// reception and host-to-device command transmission over open-collector lines.
module ps2_port_controller
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = 2048,
  parameter int unsigned SAMPLE_DELAY   = 8,
  parameter int unsigned TIMEOUT_CYCLES = 40000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       SEL,
  input  logic       REG,
  input  logic       R,
  input  logic       W,
  input  logic [7:0] DIN,
  output logic [7:0] DOUT,
  output logic       DOE,
  input  logic       KB_CLK_IN,
  input  logic       KB_DATA_IN,
  output logic       KB_CLK_OE,
  output logic       KB_DATA_OE,
  output logic       IRQ
);

  localparam int unsigned CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  ps2_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       bit_cnt_q;
  logic [7:0]       shift_q, rx_data_q, tx_data_q;
  logic             rx_par_q;
  logic             rx_valid_q, tx_busy_q, parity_err_q, frame_err_q;
  logic             ack_err_q, timeout_q, overrun_q;
  logic             clk_oe_q, data_oe_q, irq_q;
  logic             rx_valid_d;

  logic             clk_s, data_s, fall_s, strobe_s;
  logic             rd_data_s, wr_data_s, wr_stat_s, to_hit_s, rx_good_s;
  logic [7:0]       status_s;

  ps2_line_sync #(.SAMPLE_DELAY(SAMPLE_DELAY)) u_sync (
    .clk_i    (CLK),
    .rst_ni   (RST),
    .kb_clk_i (KB_CLK_IN),
    .kb_data_i(KB_DATA_IN),
    .clk_s_o  (clk_s),
    .data_s_o (data_s),
    .fall_o   (fall_s),
    .strobe_o (strobe_s)
  );

  assign rd_data_s = SEL & ~R & ~REG;
  assign wr_data_s = SEL & ~W & ~REG;
  assign wr_stat_s = SEL & ~W & REG;
  assign to_hit_s  = ~fall_s & (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign rx_good_s = (state_q == ST_RX) & ~tx_busy_q & ~to_hit_s & strobe_s
                   & (bit_cnt_q == STOP_IDX) & data_s & (^{rx_par_q, shift_q});

  assign DOE        = SEL & ~R;
  assign KB_CLK_OE  = clk_oe_q;
  assign KB_DATA_OE = data_oe_q;
  assign IRQ        = irq_q;

  always_comb begin
    status_s                  = 8'h00;
    status_s[STAT_RX_VALID]   = rx_valid_q;
    status_s[STAT_TX_BUSY]    = tx_busy_q;
    status_s[STAT_PARITY_ERR] = parity_err_q;
    status_s[STAT_FRAME_ERR]  = frame_err_q;
    status_s[STAT_ACK_ERR]    = ack_err_q;
    status_s[STAT_TIMEOUT]    = timeout_q;
    status_s[STAT_OVERRUN]    = overrun_q;
    if (SEL && !R) begin
      DOUT = REG ? status_s : rx_data_q;
    end else begin
      DOUT = 8'h00;
    end
  end

  // A byte stored in the same cycle as a data read wins over the read's clear.
  always_comb begin
    if (rx_good_s) begin
      rx_valid_d = 1'b1;
    end else if (rd_data_s) begin
      rx_valid_d = 1'b0;
    end else begin
      rx_valid_d = rx_valid_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      bit_cnt_q    <= 4'd0;
      shift_q      <= 8'h00;
      rx_data_q    <= 8'h00;
      tx_data_q    <= 8'h00;
      rx_par_q     <= 1'b0;
      rx_valid_q   <= 1'b0;
      tx_busy_q    <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      ack_err_q    <= 1'b0;
      timeout_q    <= 1'b0;
      overrun_q    <= 1'b0;
      clk_oe_q     <= 1'b0;
      data_oe_q    <= 1'b0;
      irq_q        <= 1'b1;
    end else begin
      rx_valid_q <= rx_valid_d;
      irq_q      <= ~rx_valid_d;
      if (wr_stat_s) begin
        if (DIN[STAT_PARITY_ERR]) parity_err_q <= 1'b0;
        if (DIN[STAT_FRAME_ERR])  frame_err_q  <= 1'b0;
        if (DIN[STAT_ACK_ERR])    ack_err_q    <= 1'b0;
        if (DIN[STAT_TIMEOUT])    timeout_q    <= 1'b0;
        if (DIN[STAT_OVERRUN])    overrun_q    <= 1'b0;
      end
      if (wr_data_s && !tx_busy_q) begin
        tx_data_q <= DIN;
        tx_busy_q <= 1'b1;
      end
      if (rx_good_s) begin
        rx_data_q <= shift_q;
        if (rx_valid_q && !rd_data_s) overrun_q <= 1'b1;
      end

      case (state_q)
        ST_IDLE: begin
          cnt_q     <= '0;
          bit_cnt_q <= 4'd0;
          if (tx_busy_q) begin
            state_q  <= ST_TX_INHIBIT;
            clk_oe_q <= 1'b1;
          end else if (fall_s) begin
            state_q <= ST_RX;
          end
        end
        ST_RX: begin
          cnt_q <= fall_s ? '0 : cnt_q + CNT_W'(1);
          if (tx_busy_q) begin
            state_q  <= ST_TX_INHIBIT;
            clk_oe_q <= 1'b1;
            cnt_q    <= '0;
          end else if (to_hit_s) begin
            timeout_q <= 1'b1;
            state_q   <= ST_IDLE;
          end else if (strobe_s) begin
            bit_cnt_q <= bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd0) begin
              if (data_s) begin
                frame_err_q <= 1'b1;
                state_q     <= ST_IDLE;
              end
            end else if (bit_cnt_q < PARITY_IDX) begin
              shift_q <= {data_s, shift_q[7:1]};
            end else if (bit_cnt_q == PARITY_IDX) begin
              rx_par_q <= data_s;
            end else begin
              if (!data_s) frame_err_q <= 1'b1;
              if (!(^{rx_par_q, shift_q})) parity_err_q <= 1'b1;
              state_q <= ST_IDLE;
            end
          end
        end
        ST_TX_INHIBIT: begin
          if (cnt_q == CNT_W'(INHIBIT_CYCLES - 1)) begin
            state_q   <= ST_TX_RTS;
            data_oe_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_TX_RTS: begin
          clk_oe_q  <= 1'b0;
          cnt_q     <= '0;
          bit_cnt_q <= 4'd0;
          state_q   <= ST_TX_BITS;
        end
        ST_TX_BITS, ST_TX_ACK: begin
          cnt_q <= fall_s ? '0 : cnt_q + CNT_W'(1);
          if (to_hit_s) begin
            timeout_q <= 1'b1;
            tx_busy_q <= 1'b0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            state_q   <= ST_IDLE;
          end else if (strobe_s && state_q == ST_TX_ACK) begin
            ack_err_q <= data_s;
            state_q   <= ST_TX_WAIT_IDLE;
          end else if (strobe_s) begin
            bit_cnt_q <= bit_cnt_q + 4'd1;
            if (bit_cnt_q < 4'd8) begin
              data_oe_q <= ~tx_data_q[bit_cnt_q[2:0]];
            end else if (bit_cnt_q == 4'd8) begin
              data_oe_q <= ~odd_parity(tx_data_q);
            end else begin
              data_oe_q <= 1'b0;
              state_q   <= ST_TX_ACK;
            end
          end
        end
        ST_TX_WAIT_IDLE: begin
          if (clk_s && data_s) begin
            tx_busy_q <= 1'b0;
            state_q   <= ST_IDLE;
          end
        end
        default: begin
          clk_oe_q  <= 1'b0;
          data_oe_q <= 1'b0;
          state_q   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
